// File: rtl/control_defs.sv
// rtl/control_defs.sv - shared opcodes, state encoding, select codes and output bundle for the control unit
package control_defs;

  typedef enum logic [2:0] {
    F_LO = 3'd0,
    F_HI = 3'd1,
    DEC  = 3'd2,
    EX1  = 3'd3,
    EX2  = 3'd4,
    HALT = 3'd5
  } cu_state_e;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_BRA = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_DEC  = 2'b10;
  localparam logic [1:0] FUN_INC  = 2'b11;

  localparam logic [3:0] ALU_IDLE  = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;

  localparam logic [1:0] ARF_PC = 2'd0;
  localparam logic [1:0] ARF_AR = 2'd1;
  localparam logic [1:0] ARF_SP = 2'd2;

  localparam logic [3:0] ARF_EN_PC = 4'b1000;
  localparam logic [3:0] ARF_EN_AR = 4'b0100;
  localparam logic [3:0] ARF_EN_SP = 4'b0010;

  localparam logic [1:0] MUX_ALU = 2'd0;
  localparam logic [1:0] MUX_MEM = 2'd1;
  localparam logic [1:0] MUX_IMM = 2'd2;

  typedef struct packed {
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_t_sel;
    logic [3:0] rf_r_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_a_sel;
    logic [1:0] arf_out_b_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_r_sel;
    logic [1:0] ir_funsel;
    logic       ir_enable;
    logic       ir_lh;
    logic       mem_wr;
    logic       mem_cs_n;
  } cu_ctrl_t;

  // R1 sits in the MSB of the enable vector, so index 0 maps to 4'b1000.
  function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [3:0] alu_for_op(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_IDLE;
    endcase
  endfunction

  function automatic cu_ctrl_t ctrl_idle();
    cu_ctrl_t c;
    c               = '0;
    c.rf_fun_sel    = FUN_LOAD;
    c.arf_fun_sel   = FUN_LOAD;
    c.ir_funsel     = FUN_LOAD;
    c.alu_fun_sel   = ALU_IDLE;
    c.mem_cs_n      = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational map from (state, IR high byte, Z) to the datapath control bundle
module cu_decoder
  import control_defs::*;
(
  input  cu_state_e  state_i,
  input  logic       reset_i,
  input  logic [7:0] ir_high_i,
  input  logic       z_i,
  output cu_ctrl_t   ctrl_o
);

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       take_br;

  assign op = ir_high_i[7:4];
  assign rd = ir_high_i[3:2];
  assign rs = ir_high_i[1:0];

  assign take_br = (op == OP_BRA) || ((op == OP_BEQ) && z_i) || ((op == OP_BNE) && !z_i);

  always_comb begin
    ctrl_o = ctrl_idle();
    // Reset wins over every state so an aborted store never reaches memory.
    if (reset_i) begin
      ctrl_o.arf_fun_sel = FUN_CLR;
      ctrl_o.arf_r_sel   = 4'b1110;
      ctrl_o.rf_fun_sel  = FUN_CLR;
      ctrl_o.rf_r_sel    = 4'b1111;
    end else begin
      case (state_i)
        F_LO, F_HI: begin
          ctrl_o.arf_out_b_sel = ARF_PC;
          ctrl_o.mem_cs_n      = 1'b0;
          ctrl_o.ir_enable     = 1'b1;
          ctrl_o.ir_lh         = (state_i == F_HI);
          ctrl_o.ir_funsel     = FUN_LOAD;
          ctrl_o.arf_r_sel     = ARF_EN_PC;
          ctrl_o.arf_fun_sel   = FUN_INC;
        end
        EX1: begin
          case (op)
            OP_LDI: begin
              ctrl_o.mux_a_sel  = MUX_IMM;
              ctrl_o.rf_r_sel   = rf_onehot(rd);
              ctrl_o.rf_fun_sel = FUN_LOAD;
            end
            OP_LD, OP_ST: begin
              ctrl_o.mux_b_sel   = MUX_IMM;
              ctrl_o.arf_r_sel   = ARF_EN_AR;
              ctrl_o.arf_fun_sel = FUN_LOAD;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              ctrl_o.mux_c_sel    = 1'b0;
              ctrl_o.rf_out_a_sel = {1'b0, rd};
              ctrl_o.rf_out_b_sel = {1'b0, rs};
              ctrl_o.alu_fun_sel  = alu_for_op(op);
              ctrl_o.mux_a_sel    = MUX_ALU;
              ctrl_o.rf_r_sel     = rf_onehot(rd);
              ctrl_o.rf_fun_sel   = FUN_LOAD;
            end
            OP_INC, OP_DEC: begin
              ctrl_o.rf_fun_sel = (op == OP_INC) ? FUN_INC : FUN_DEC;
              ctrl_o.rf_r_sel   = rf_onehot(rd);
            end
            OP_MOV: begin
              ctrl_o.rf_out_b_sel = {1'b0, rs};
              ctrl_o.alu_fun_sel  = ALU_PASSB;
              ctrl_o.mux_a_sel    = MUX_ALU;
              ctrl_o.rf_r_sel     = rf_onehot(rd);
              ctrl_o.rf_fun_sel   = FUN_LOAD;
            end
            OP_BRA, OP_BEQ, OP_BNE: begin
              if (take_br) begin
                ctrl_o.mux_b_sel   = MUX_IMM;
                ctrl_o.arf_r_sel   = ARF_EN_PC;
                ctrl_o.arf_fun_sel = FUN_LOAD;
              end
            end
            default: ;
          endcase
        end
        EX2: begin
          if (op == OP_LD) begin
            ctrl_o.arf_out_b_sel = ARF_AR;
            ctrl_o.mem_cs_n      = 1'b0;
            ctrl_o.mux_a_sel     = MUX_MEM;
            ctrl_o.rf_r_sel      = rf_onehot(rd);
            ctrl_o.rf_fun_sel    = FUN_LOAD;
          end else if (op == OP_ST) begin
            ctrl_o.rf_out_b_sel  = {1'b0, rs};
            ctrl_o.alu_fun_sel   = ALU_PASSB;
            ctrl_o.arf_out_b_sel = ARF_AR;
            ctrl_o.mem_cs_n      = 1'b0;
            ctrl_o.mem_wr        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer driving the ALU_System datapath
module control_unit
  import control_defs::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] IR_High,
  input  logic [3:0] ALU_ZCNO,
  output logic [1:0] MuxASel,
  output logic [1:0] MuxBSel,
  output logic       MuxCSel,
  output logic [2:0] RF_OutASel,
  output logic [2:0] RF_OutBSel,
  output logic [1:0] RF_FunSel,
  output logic [3:0] RF_TSel,
  output logic [3:0] RF_RSel,
  output logic [3:0] ALU_FunSel,
  output logic [1:0] ARF_OutASel,
  output logic [1:0] ARF_OutBSel,
  output logic [1:0] ARF_FunSel,
  output logic [3:0] ARF_RSel,
  output logic [1:0] IR_Funsel,
  output logic       IR_Enable,
  output logic       IR_LH,
  output logic       Mem_WR,
  output logic       Mem_CS,
  output logic       Halted,
  output logic       Illegal
);

  cu_state_e  state_q, state_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  logic [3:0] op;
  logic       op_illegal;
  logic       unused_flags;
  cu_ctrl_t   ctrl;

  assign op           = IR_High[7:4];
  assign op_illegal   = (op[3:1] == 3'b111);
  assign unused_flags = ^ALU_ZCNO[2:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_LO: state_d = F_HI;
      F_HI: state_d = DEC;
      DEC:  state_d = EX1;
      EX1: begin
        if (op == OP_LD || op == OP_ST) begin
          state_d = EX2;
        end else if (op == OP_HLT) begin
          state_d = HALT;
        end else if (op_illegal) begin
          state_d = ILLEGAL_HALT ? HALT : F_LO;
        end else begin
          state_d = F_LO;
        end
      end
      EX2:     state_d = F_LO;
      HALT:    state_d = HALT;
      default: state_d = F_LO;
    endcase
  end

  assign illegal_d = (state_q == EX1) && op_illegal;
  assign halted_d  = (state_d == HALT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= F_LO;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  cu_decoder u_decoder (
    .state_i   (state_q),
    .reset_i   (Reset),
    .ir_high_i (IR_High),
    .z_i       (ALU_ZCNO[3]),
    .ctrl_o    (ctrl)
  );

  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign RF_OutASel  = ctrl.rf_out_a_sel;
  assign RF_OutBSel  = ctrl.rf_out_b_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_TSel     = ctrl.rf_t_sel;
  assign RF_RSel     = ctrl.rf_r_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ARF_OutASel = ctrl.arf_out_a_sel;
  assign ARF_OutBSel = ctrl.arf_out_b_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RSel    = ctrl.arf_r_sel;
  assign IR_Funsel   = ctrl.ir_funsel;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_LH       = ctrl.ir_lh;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs_n;
  assign Halted      = halted_q;
  assign Illegal     = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit: per-cycle expectations queued at drive time, compared at negedge
module tb_control_unit;

  logic       Clock, Reset;
  logic [7:0] IR_High;
  logic [3:0] ALU_ZCNO;
  logic [1:0] MuxASel, MuxBSel;
  logic       MuxCSel;
  logic [2:0] RF_OutASel, RF_OutBSel;
  logic [1:0] RF_FunSel;
  logic [3:0] RF_TSel, RF_RSel, ALU_FunSel;
  logic [1:0] ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0] ARF_RSel;
  logic [1:0] IR_Funsel;
  logic       IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal;

  localparam int SIG_MUXA  = 0;
  localparam int SIG_MUXB  = 1;
  localparam int SIG_MUXC  = 2;
  localparam int SIG_OUTA  = 3;
  localparam int SIG_OUTB  = 4;
  localparam int SIG_RFFUN = 5;
  localparam int SIG_RFR   = 6;
  localparam int SIG_ALU   = 7;
  localparam int SIG_AOUTB = 8;
  localparam int SIG_AFUN  = 9;
  localparam int SIG_AR    = 10;
  localparam int SIG_IREN  = 11;
  localparam int SIG_IRLH  = 12;
  localparam int SIG_MWR   = 13;
  localparam int SIG_MCS   = 14;
  localparam int SIG_HALT  = 15;
  localparam int SIG_ILL   = 16;
  localparam int SIG_TSEL  = 17;

  localparam int ALU_ADD_C   = 4;
  localparam int ALU_PASSB_C = 2;

  typedef struct {
    int    cyc;
    string tag;
    int    sig;
    int    val;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t mon_item;
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  control_unit #(.ILLEGAL_HALT(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .IR_High(IR_High), .ALU_ZCNO(ALU_ZCNO),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_TSel(RF_TSel), .RF_RSel(RF_RSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .Halted(Halted), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] get_sig(input int id);
    case (id)
      SIG_MUXA:  return 32'(MuxASel);
      SIG_MUXB:  return 32'(MuxBSel);
      SIG_MUXC:  return 32'(MuxCSel);
      SIG_OUTA:  return 32'(RF_OutASel);
      SIG_OUTB:  return 32'(RF_OutBSel);
      SIG_RFFUN: return 32'(RF_FunSel);
      SIG_RFR:   return 32'(RF_RSel);
      SIG_ALU:   return 32'(ALU_FunSel);
      SIG_AOUTB: return 32'(ARF_OutBSel);
      SIG_AFUN:  return 32'(ARF_FunSel);
      SIG_AR:    return 32'(ARF_RSel);
      SIG_IREN:  return 32'(IR_Enable);
      SIG_IRLH:  return 32'(IR_LH);
      SIG_MWR:   return 32'(Mem_WR);
      SIG_MCS:   return 32'(Mem_CS);
      SIG_HALT:  return 32'(Halted);
      SIG_ILL:   return 32'(Illegal);
      SIG_TSEL:  return 32'(RF_TSel);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge Clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_item = sb.pop_front();
      check_val(mon_item.tag, get_sig(mon_item.sig), mon_item.val);
    end
  end

  task automatic expect_sig(input string tag, input int sig, input int val);
    sb_item_t it;
    it.cyc = cyc;
    it.tag = tag;
    it.sig = sig;
    it.val = val;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Entered at the start of an F_LO cycle; leaves the bench at the start of EX1.
  task automatic fetch(input logic [7:0] ir, input logic [3:0] flags);
    IR_High  = ir;
    ALU_ZCNO = flags;
    expect_sig("flo_cs",   SIG_MCS,   0);
    expect_sig("flo_lh",   SIG_IRLH,  0);
    expect_sig("flo_iren", SIG_IREN,  1);
    expect_sig("flo_ar",   SIG_AR,    8);
    expect_sig("flo_afun", SIG_AFUN,  3);
    expect_sig("flo_aoutb",SIG_AOUTB, 0);
    step();
    expect_sig("fhi_lh",   SIG_IRLH,  1);
    expect_sig("fhi_cs",   SIG_MCS,   0);
    expect_sig("fhi_ar",   SIG_AR,    8);
    step();
    expect_sig("dec_cs",   SIG_MCS,   1);
    expect_sig("dec_ar",   SIG_AR,    0);
    expect_sig("dec_rfr",  SIG_RFR,   0);
    expect_sig("dec_iren", SIG_IREN,  0);
    expect_sig("dec_tsel", SIG_TSEL,  0);
    step();
  endtask

  initial begin
    Reset    = 1'b1;
    IR_High  = 8'h00;
    ALU_ZCNO = 4'h0;

    step();
    expect_sig("rst_ar",   SIG_AR,    14);
    expect_sig("rst_afun", SIG_AFUN,  0);
    expect_sig("rst_rfr",  SIG_RFR,   15);
    expect_sig("rst_rfun", SIG_RFFUN, 0);
    expect_sig("rst_cs",   SIG_MCS,   1);
    expect_sig("rst_wr",   SIG_MWR,   0);
    expect_sig("rst_halt", SIG_HALT,  0);
    expect_sig("rst_ill",  SIG_ILL,   0);
    step();
    Reset = 1'b0;

    fetch(8'h05, 4'h0);
    expect_sig("ldi_muxa", SIG_MUXA,  2);
    expect_sig("ldi_rfr",  SIG_RFR,   4);
    expect_sig("ldi_rfun", SIG_RFFUN, 1);
    expect_sig("ldi_ar",   SIG_AR,    0);
    step();

    fetch(8'h37, 4'h0);
    expect_sig("add_outa", SIG_OUTA,  1);
    expect_sig("add_outb", SIG_OUTB,  3);
    expect_sig("add_muxc", SIG_MUXC,  0);
    expect_sig("add_muxa", SIG_MUXA,  0);
    expect_sig("add_rfr",  SIG_RFR,   4);
    expect_sig("add_rfun", SIG_RFFUN, 1);
    expect_sig("add_alu",  SIG_ALU,   ALU_ADD_C);
    step();

    fetch(8'h74, 4'h0);
    expect_sig("inc_rfun", SIG_RFFUN, 3);
    expect_sig("inc_rfr",  SIG_RFR,   4);
    step();

    fetch(8'h22, 4'h0);
    expect_sig("st1_ar",   SIG_AR,    4);
    expect_sig("st1_muxb", SIG_MUXB,  2);
    expect_sig("st1_afun", SIG_AFUN,  1);
    expect_sig("st1_wr",   SIG_MWR,   0);
    step();
    expect_sig("st2_wr",   SIG_MWR,   1);
    expect_sig("st2_cs",   SIG_MCS,   0);
    expect_sig("st2_aoutb",SIG_AOUTB, 1);
    expect_sig("st2_outb", SIG_OUTB,  2);
    expect_sig("st2_alu",  SIG_ALU,   ALU_PASSB_C);
    step();

    fetch(8'hB0, 4'b1000);
    expect_sig("beq_t_ar",   SIG_AR,   8);
    expect_sig("beq_t_muxb", SIG_MUXB, 2);
    expect_sig("beq_t_afun", SIG_AFUN, 1);
    step();

    fetch(8'hB0, 4'b0000);
    expect_sig("beq_n_ar",   SIG_AR,   0);
    expect_sig("beq_n_muxb", SIG_MUXB, 0);
    step();

    fetch(8'hC0, 4'b0000);
    expect_sig("bne_t_ar",   SIG_AR,   8);
    step();

    fetch(8'h22, 4'h0);
    step();
    Reset = 1'b1;
    expect_sig("abort_wr", SIG_MWR, 0);
    expect_sig("abort_cs", SIG_MCS, 1);
    expect_sig("abort_ar", SIG_AR,  14);
    step();
    Reset = 1'b0;

    fetch(8'hE0, 4'h0);
    expect_sig("ill_ex1",   SIG_ILL,  0);
    step();
    expect_sig("ill_pulse", SIG_ILL,  1);
    expect_sig("ill_halt",  SIG_HALT, 1);
    expect_sig("halt_cs",   SIG_MCS,  1);
    expect_sig("halt_ar",   SIG_AR,   0);
    step();
    expect_sig("ill_drop",  SIG_ILL,  0);
    expect_sig("halt_hold", SIG_HALT, 1);
    step();
    expect_sig("halt_hold2",SIG_HALT, 1);
    expect_sig("halt_iren", SIG_IREN, 0);
    Reset = 1'b1;
    expect_sig("hrst_ar",   SIG_AR,   14);
    expect_sig("hrst_halt", SIG_HALT, 1);
    step();
    Reset = 1'b0;
    expect_sig("post_halt", SIG_HALT, 0);
    expect_sig("post_cs",   SIG_MCS,  0);
    expect_sig("post_lh",   SIG_IRLH, 0);
    expect_sig("post_ar",   SIG_AR,   8);
    step();

    @(negedge Clock);
    #1;
    check_val("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired sequencer that drives every control input of ALU_System, making the datapath a working CPU.
- Fetches a 16-bit instruction in two memory reads (low byte, then high byte), decodes IR[15:8] and executes in 1–2 cycles.
- Its only inputs from the datapath are the IR high byte and ALU_ZCNO.

Parameters:
ILLEGAL_HALT, 0, 1: opcodes 0xE/0xF halt; 0: they execute as NOP.

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high
IR_High  in  8  datapath `out` (IR[15:8])
ALU_ZCNO  in  4  ALU flags, bit3=Z
MuxASel, MuxBSel  out  2 each  datapath mux selects
MuxCSel  out  1  datapath mux select
RF_OutASel, RF_OutBSel  out  3 each  0..3=R1..R4
RF_FunSel  out  2  00 clear, 01 load, 10 decrement, 11 increment
RF_TSel  out  4  temp-register enables, always 0000
RF_RSel  out  4  one-hot enable, bit3=R1..bit0=R4
ALU_FunSel  out  4  operation code per package
ARF_OutASel, ARF_OutBSel  out  2 each  0=PC, 1=AR, 2=SP
ARF_FunSel  out  2  same coding as RF_FunSel
ARF_RSel  out  4  bit3=PC, bit2=AR, bit1=SP, bit0 unused
IR_Funsel  out  2  01=load
IR_Enable  out  1  IR write enable
IR_LH  out  1  0=low half, 1=high half
Mem_WR  out  1  1=write
Mem_CS  out  1  active-low chip select
Halted  out  1  registered, high in HALT
Illegal  out  1  registered one-cycle pulse on opcode 0xE/0xF

Behaviour:
Idle output rules:
- Every output not named in a state is idle: RF_RSel=ARF_RSel=0000, RF_TSel=0000, IR_Enable=0, Mem_CS=1, Mem_WR=0, all selects 0, FunSels 01.
- A zero enable vector means no register changes.

Reset:
- While Reset=1, outputs combinationally drive ARF_FunSel=00 with ARF_RSel=1110, and RF_FunSel=00 with RF_RSel=1111 (clears PC/AR/SP and R1..R4).
- Next state is F_LO; Halted=0, Illegal=0.
- Reset mid-instruction aborts it; no memory write is issued in the reset cycle.

Decoded fields:
- OP=IR_High[7:4], RD=IR_High[3:2], RS=IR_High[1:0].
- IMM = IR low byte, reached only via MuxASel/MuxBSel=2.

States:
- F_LO: ARF_OutBSel=PC, Mem_CS=0, IR_Enable=1, IR_LH=0, IR_Funsel=01; ARF_RSel=1000 with FunSel=11 (PC+1). Next F_HI.
- F_HI: same as F_LO with IR_LH=1. Next DEC.
- DEC: no datapath action, so IR_High is stable. Next EX1.
- EX1/EX2 by OP; each returns to F_LO when done:
  - 0 LDI: MuxASel=2, RF load RD.
  - 1 LD: EX1 AR<-IMM (MuxBSel=2, ARF_RSel=0100, load). EX2 ARF_OutBSel=AR, Mem_CS=0, MuxASel=1, RF load RD.
  - 2 ST: EX1 AR<-IMM. EX2 RF_OutBSel=RS, ALU_FunSel=PASSB, ARF_OutBSel=AR, Mem_CS=0, Mem_WR=1.
  - 3 ADD, 4 SUB, 5 AND, 6 OR: MuxCSel=0, RF_OutASel=RD, RF_OutBSel=RS, ALU op, MuxASel=0, RF load RD; flags update inside ALU.
  - 7 INC / 8 DEC: RF_FunSel=11/10 on RD; flags unchanged.
  - 9 MOV: RF_OutBSel=RS, ALU PASSB, MuxASel=0, load RD.
  - A BRA: MuxBSel=2, ARF_RSel=1000, load.
  - B BEQ / C BNE: same as BRA only if Z==1 / Z==0; otherwise idle.
  - D HLT: go to HALT.
  - E/F: Illegal pulses for 1 cycle, then go to HALT if ILLEGAL_HALT else to F_LO.
- HALT: all idle, Halted=1, exits only on Reset.

Timing and arithmetic:
- PC wraps 0xFF->0x00 (ARF increment, 8-bit).
- Instruction latency: 4 cycles single-phase, 5 for LD/ST.
- Branch Z is sampled in EX1, so it is the flag from the latest completed ALU op.

Decomposition:
- Package control_defs: opcode constants, state encoding (F_LO, F_HI, DEC, EX1, EX2, HALT), FunSel codes, ALU codes (ADD, SUB, AND, OR, PASSB), ARF/RF index constants.
- One sub-module, cu_decoder: combinational map of (state, OP, RD, RS, Z) to the output bundle.
- control_unit holds the state register plus Halted/Illegal flops.

Test Plan:
- Reset held 2 cycles then released -> ARF_RSel=1110/FunSel=00 during reset; first post-reset cycle F_LO with Mem_CS=0, IR_LH=0, ARF_RSel=1000, FunSel=11.
- IR_High=0x05 (LDI R2) -> EX1 MuxASel=2, RF_RSel=0100, RF_FunSel=01; F_LO follows.
- IR_High=0x37 (ADD R2,R4) -> RF_OutASel=1, RF_OutBSel=3, MuxCSel=0, MuxASel=0, RF_RSel=0100.
- IR_High=0x22 (ST R3) -> EX1 ARF_RSel=0100; EX2 Mem_WR=1, Mem_CS=0, ARF_OutBSel=1, RF_OutBSel=2; 5-cycle instruction.
- IR_High=0xB0 with ZCNO=1000 then 0000 -> ARF_RSel=1000 load in first case only.
- IR_High=0xE0 with ILLEGAL_HALT=1, then Reset -> Illegal 1-cycle pulse, Halted=1 held; Reset returns to F_LO with Halted=0.
